uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter UART_BASE, default 32'h0000_0000, meaning the UART register base address on the bus.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk_i  in  1  system clock.
REQ-005 The block SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid_i  in  NUM_REQ  per-requester byte pending.
REQ-007 The block SHALL have port req_data_i  in  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-008 The block SHALL have port req_ready_o  out  NUM_REQ  one-cycle accept pulse per requester.
REQ-009 The block SHALL have ports wb_adr_o (out, 32), wb_dat_o (out, 32), wb_dat_i (in, 32), wb_we_o (out, 1), wb_sel_o (out, 4), wb_stb_o (out, 1), wb_ack_i (in, 1), wb_cyc_o (out, 1), wb_stall_i (in, 1): a pipelined Wishbone master to the UART.
REQ-010 The block SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-011 The block SHALL have port grant_o  out  $clog2(NUM_REQ)  index of the requester currently being served.
REQ-012 The block SHALL have port err_o  out  1  one-cycle bus-timeout pulse.

Function
REQ-013 The block SHALL implement the states IDLE, POLL, POLL_WAIT, WRITE, WRITE_WAIT.
REQ-014 IDLE: when any req_valid_i bit is set, the block SHALL grant round-robin, starting from pointer rr_q (lowest index at or above rr_q, with wrap-around).
REQ-015 On grant in IDLE, the block SHALL pulse req_ready_o[k] for that same cycle, capture the byte, set grant_o=k and rr_q=(k+1) mod NUM_REQ, then enter POLL.
REQ-016 POLL: the block SHALL drive cyc=1, stb=1, we=0, sel=4'hF, adr=UART_BASE+0 (the SR), holding stb until a cycle in which wb_stall_i=0, then go to POLL_WAIT with stb=0 and cyc=1.
REQ-017 POLL_WAIT: on wb_ack_i, if wb_dat_i[1] (TXE)=1 the block SHALL go to WRITE; otherwise it SHALL return to POLL on the next cycle.
REQ-018 WRITE: the block SHALL drive cyc=1, stb=1, we=1, sel=4'b0001, adr=UART_BASE+12 (the TXDR), dat={24'b0,byte}, holding stb until wb_stall_i=0, then go to WRITE_WAIT.
REQ-019 WRITE_WAIT: on wb_ack_i the block SHALL deassert cyc and return to IDLE; the earliest next grant is the following cycle.
REQ-020 The block SHALL ignore wb_ack_i outside the *_WAIT states.
REQ-021 The block SHALL not change a captured byte after grant; requester inputs are don't-care until the next grant.
REQ-022 Each SR poll clears the UART PE/FE/RXOE flags; this is an accepted side effect.
REQ-023 When there is no request, the block SHALL stay in IDLE with cyc=stb=0.

Reset
REQ-024 On rst_i (asynchronous), the block SHALL force state=IDLE, rr_q=0, byte=0, all wb_* outputs=0, req_ready_o=0, grant_o=0, busy_o=0 and err_o=0.
REQ-025 Reset mid-transfer SHALL drop cyc/stb immediately; the byte is lost and no req_ready_o is reissued.

Configuration
REQ-026 With macro UART_TX_ARBITER_WDOG_EN defined, an 8-bit counter SHALL count cycles in POLL_WAIT/WRITE_WAIT and reset on each state entry.
REQ-027 With UART_TX_ARBITER_WDOG_EN defined, reaching 255 cycles without ack SHALL drop cyc, pulse err_o for one cycle and go to IDLE, with the byte discarded.
REQ-028 Without UART_TX_ARBITER_WDOG_EN, the block SHALL wait indefinitely for ack and err_o SHALL be tied 0.

Structure
REQ-029 Package uart_tx_arbiter_pkg SHALL hold the state enum, SR_OFFSET=0, TXDR_OFFSET=12, SR_TXE_BIT=1 and WDOG_LIMIT=255.
REQ-030 Sub-module rr_arbiter SHALL compute the round-robin one-hot grant from the request vector and rr_q (combinational), instantiated once.

Verification
REQ-031 A bench SHALL cover: req 2 valid byte 8'hA5, TXE=1, no stall -> ready[2] pulse, SR read at adr 0, write at adr 12 with dat 32'h0000_00A5 and sel 4'b0001, back in IDLE after 2 acks.
REQ-032 A bench SHALL cover: all 4 requesters valid continuously -> grant order 0,1,2,3,0, each served exactly once per rotation.
REQ-033 A bench SHALL cover: SR returns TXE=0 three times, then TXE=1 -> 4 polls then exactly 1 write; busy_o high throughout.
REQ-034 A bench SHALL cover: wb_stall_i high for 5 cycles during WRITE -> stb, adr and dat held stable for those 5 cycles; a single write is issued.
REQ-035 A bench SHALL cover: rst_i asserted in WRITE_WAIT -> cyc/stb 0 in the same cycle; after release the next grant starts from requester 0.
REQ-036 A bench SHALL cover, with UART_TX_ARBITER_WDOG_EN: no ack for 255 cycles in POLL_WAIT -> err_o single pulse, cyc 0, state IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, POLL, POLL_WAIT, WRITE, WRITE_WAIT} state_t;
  localparam logic [31:0] SR_OFFSET   = 32'd0;
  localparam logic [31:0] TXDR_OFFSET = 32'd12;
  localparam int          SR_TXE_BIT  = 1;
  localparam int          WDOG_LIMIT  = 255;
endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: lowest requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);
  localparam int PW = $clog2(NUM_REQ);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a pipelined Wishbone UART: poll SR for TXE, then write TXDR.
// Optional bus watchdog enabled by defining UART_TX_ARBITER_WDOG_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] UART_BASE = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [31:0]                wb_adr_o,
  output logic [31:0]                wb_dat_o,
  input  logic [31:0]                wb_dat_i,
  output logic                       wb_we_o,
  output logic [3:0]                 wb_sel_o,
  output logic                       wb_stb_o,
  input  logic                       wb_ack_i,
  output logic                       wb_cyc_o,
  input  logic                       wb_stall_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       err_o
);
  localparam int PW = $clog2(NUM_REQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, grant_q, gnt_idx;
  logic [7:0]      byte_q;
  logic [NUM_REQ-1:0] gnt;
  logic            any, timeout;
  logic            unused_dat;

  assign unused_dat = ^{wb_dat_i[31:SR_TXE_BIT+1], wb_dat_i[SR_TXE_BIT-1:0]};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid_i),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

`ifdef UART_TX_ARBITER_WDOG_EN
  logic [7:0] wdog_q;
  logic       err_q;
  assign timeout = (state_q == POLL_WAIT || state_q == WRITE_WAIT) && !wb_ack_i &&
                   (wdog_q == 8'(WDOG_LIMIT - 1));

  // Counter restarts on every state change so each wait phase gets a full budget.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_d != state_q)
        wdog_q <= '0;
      else if (state_q == POLL_WAIT || state_q == WRITE_WAIT)
        wdog_q <= wdog_q + 8'd1;
    end
  end
  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_sel_o    = 4'h0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so an asserted rst_i never issues an accept.
        if (any && !rst_i) begin
          req_ready_o = gnt;
          state_d     = POLL;
        end
      end
      POLL: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'hF;
        wb_adr_o = UART_BASE + SR_OFFSET;
        if (!wb_stall_i) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        wb_cyc_o = 1'b1;
        if (wb_ack_i)     state_d = wb_dat_i[SR_TXE_BIT] ? WRITE : POLL;
        else if (timeout) state_d = IDLE;
      end
      WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = 4'b0001;
        wb_adr_o = UART_BASE + TXDR_OFFSET;
        wb_dat_o = {24'b0, byte_q};
        if (!wb_stall_i) state_d = WRITE_WAIT;
      end
      WRITE_WAIT: begin
        wb_cyc_o = 1'b1;
        if (wb_ack_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      byte_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any) begin
        byte_q  <= req_data_i[8*gnt_idx +: 8];
        grant_q <= gnt_idx;
        rr_q    <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign grant_o = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios, a Wishbone slave model and a per-cycle checker.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [31:0]    wb_adr, wb_dat_o, wb_dat_i;
  logic           wb_we, wb_stb, wb_ack, wb_cyc, wb_stall;
  logic [3:0]     wb_sel;
  logic           busy, err;
  logic [1:0]     grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .UART_BASE(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack),
    .wb_cyc_o(wb_cyc), .wb_stall_i(wb_stall), .busy_o(busy), .grant_o(grant), .err_o(err)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference round-robin: first valid index scanning upward from rr, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = 0; i < N; i++)
      if (v[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // Slave state
  bit   sr_q[$];
  int   stall_left = 0, stall_wr_cycles = 0;
  bit   hold_rd_ack = 0, hold_wr_ack = 0;
  int   reads = 0, writes = 0, acks = 0;
  logic [31:0] last_rd_adr, last_wr_adr, last_wr_dat;
  logic [3:0]  last_wr_sel;

  initial begin
    bit acc, acc_we, txe;
    logic [31:0] a_adr, a_dat;
    logic [3:0]  a_sel;
    wb_ack = 1'b0; wb_dat_i = '0; wb_stall = 1'b0;
    forever begin
      @(negedge clk);
      acc = wb_cyc && wb_stb && !wb_stall && !rst;
      acc_we = wb_we; a_adr = wb_adr; a_dat = wb_dat_o; a_sel = wb_sel;
      @(posedge clk); #1;
      wb_ack = 1'b0; wb_dat_i = '0;
      if (acc && !acc_we) begin
        reads++; last_rd_adr = a_adr;
        if (!hold_rd_ack) begin
          txe = (sr_q.size() != 0) ? sr_q.pop_front() : 1'b1;
          wb_ack = 1'b1; acks++;
          wb_dat_i = 32'hFFFF_FFFD | (32'(txe) << 1);
        end
      end
      if (acc && acc_we) begin
        writes++; last_wr_adr = a_adr; last_wr_dat = a_dat; last_wr_sel = a_sel;
        if (!hold_wr_ack) begin wb_ack = 1'b1; acks++; end
      end
      wb_stall = 1'b0;
      if (!rst && wb_stb && wb_we && stall_left > 0) begin
        wb_stall = 1'b1; stall_left--; stall_wr_cycles++;
      end
    end
  end

  // Model of arbitration and bus rules, checked every cycle
  int   m_rr = 0, m_grant = 0, run = 0, err_cnt = 0;
  logic [7:0] m_byte = '0;
  int   glog[$];
  logic [N-1:0] last_ready = '0;
  bit   p_hold = 0;
  logic [31:0] p_adr, p_dat;
  logic p_we;

  always @(negedge clk) begin
    int k;
    bit exp_err;
    if (rst) begin
      chk("rst_cyc", wb_cyc, 0); chk("rst_stb", wb_stb, 0);
      chk("rst_ready", req_ready, 0); chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0); chk("rst_err", err, 0);
      m_rr = 0; m_grant = 0; run = 0; p_hold = 0;
    end else begin
      chk("busy_vs_cyc", busy, wb_cyc);
      if (!wb_cyc) chk("stb_without_cyc", wb_stb, 0);
`ifdef UART_TX_ARBITER_WDOG_EN
      exp_err = (run == 255);
`else
      exp_err = 1'b0;
`endif
      chk("err", err, exp_err);
      if (err) begin err_cnt++; chk("err_cyc", wb_cyc, 0); end
      if (!busy) begin
        k = pick(req_valid, m_rr);
        chk("ready", req_ready, (k < 0) ? 32'd0 : (32'd1 << k));
        if (k >= 0 && req_ready != 0) begin
          m_byte = req_data[8*k +: 8]; m_grant = k; m_rr = (k + 1) % N;
          glog.push_back(k); last_ready = req_ready;
        end
      end else begin
        chk("ready_busy", req_ready, 0);
        chk("grant", grant, m_grant);
      end
      if (wb_stb) begin
        if (!wb_we) begin
          chk("rd_adr", wb_adr, 32'd0); chk("rd_sel", wb_sel, 4'hF);
        end else begin
          chk("wr_adr", wb_adr, 32'd12); chk("wr_sel", wb_sel, 4'b0001);
          chk("wr_dat", wb_dat_o, {24'b0, m_byte});
        end
      end
      if (p_hold) begin
        chk("hold_stb", wb_stb, 1); chk("hold_adr", wb_adr, p_adr);
        chk("hold_dat", wb_dat_o, p_dat); chk("hold_we", wb_we, p_we);
      end
      p_hold = wb_stb && wb_stall; p_adr = wb_adr; p_dat = wb_dat_o; p_we = wb_we;
      run = (wb_cyc && !wb_stb && !wb_ack) ? run + 1 : 0;
    end
  end

  task automatic wait_grants(input int n, input string name);
    int c = 0;
    while (glog.size() < n && c < 300) begin @(negedge clk); #1; c++; end
    chk(name, glog.size(), n);
  endtask

  task automatic serve(input int k, input logic [7:0] b);
    int n0;
    n0 = glog.size();
    req_data[8*k +: 8] = b;
    req_valid[k] = 1'b1;
    wait_grants(n0 + 1, "grant_seen");
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int c = 0;
    while (busy && c < bound) begin @(posedge clk); #2; c++; end
    chk(name, busy, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int r0, w0, a0, s0, e0;
    int exp_order[5];
    rst = 1'b1; req_valid = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_cyc", wb_cyc, 0);
    chk("reset_adr", wb_adr, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single byte, TXE set, no stall
    r0 = reads; w0 = writes; a0 = acks;
    serve(2, 8'hA5);
    wait_idle(100, "t1_idle");
    chk("t1_ready_vec", last_ready, 4'b0100);
    chk("t1_reads", reads - r0, 1);
    chk("t1_writes", writes - w0, 1);
    chk("t1_acks", acks - a0, 2);
    chk("t1_rd_adr", last_rd_adr, 32'd0);
    chk("t1_wr_adr", last_wr_adr, 32'd12);
    chk("t1_wr_dat", last_wr_dat, 32'h0000_00A5);
    chk("t1_wr_sel", last_wr_sel, 4'b0001);
    chk("t1_grant", grant, 2);

    // All requesters valid: rotation 0,1,2,3,0
    do_reset();
    glog.delete();
    req_data = 32'h44_33_22_11;
    req_valid = 4'hF;
    wait_grants(5, "t2_grants");
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle(100, "t2_idle");
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk("t2_order", glog[i], exp_order[i]);

    // SR reports TXE=0 three times
    r0 = reads; w0 = writes;
    sr_q = '{1'b0, 1'b0, 1'b0};
    serve(1, 8'h3C);
    wait_idle(200, "t3_idle");
    chk("t3_polls", reads - r0, 4);
    chk("t3_writes", writes - w0, 1);
    chk("t3_wr_dat", last_wr_dat, 32'h0000_003C);

    // Stall held for 5 cycles during WRITE
    w0 = writes; s0 = stall_wr_cycles;
    stall_left = 5;
    serve(3, 8'h5A);
    wait_idle(200, "t4_idle");
    chk("t4_stall_cycles", stall_wr_cycles - s0, 5);
    chk("t4_writes", writes - w0, 1);
    chk("t4_wr_dat", last_wr_dat, 32'h0000_005A);

    // Reset while in WRITE_WAIT, then rotation restarts at 0
    w0 = writes;
    hold_wr_ack = 1'b1;
    serve(0, 8'h11);
    begin
      int c = 0;
      while (writes == w0 && c < 100) begin @(posedge clk); #2; c++; end
    end
    chk("t5_in_write_wait_cyc", wb_cyc, 1);
    chk("t5_in_write_wait_stb", wb_stb, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_cyc", wb_cyc, 0);
    chk("t5_rst_stb", wb_stb, 0);
    @(posedge clk); #1;
    rst = 1'b0; hold_wr_ack = 1'b0;
    glog.delete();
    req_data = 32'hDD_CC_BB_AA;
    req_valid = 4'hE;
    req_valid[0] = 1'b1;
    wait_grants(1, "t5_grant_seen");
    @(posedge clk); #1;
    req_valid = '0;
    chk("t5_first_grant", glog[0], 0);
    wait_idle(100, "t5_idle");

`ifdef UART_TX_ARBITER_WDOG_EN
    // No ack in POLL_WAIT: watchdog fires after 255 cycles
    w0 = writes; e0 = err_cnt;
    hold_rd_ack = 1'b1;
    serve(2, 8'h77);
    wait_idle(400, "t6_idle");
    hold_rd_ack = 1'b0;
    chk("t6_err_pulses", err_cnt - e0, 1);
    chk("t6_no_write", writes - w0, 0);
`else
    e0 = err_cnt;
    chk("err_tied_low", e0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
